mips_cpu_writeback_arbiter: RTL
===============================

# mips_cpu_writeback_arbiter

Write-side initiator for the MIPS register file. Merges the single-cycle ALU result path and the multi-cycle load/mul-div result path into the register file's single write port (WENREG/Rd/RdDATA). Buffers long-latency results while the ALU owns the port, and reports pending destinations to the hazard unit. Sits between the execute/memory stages and the register file.

## Interface
- DEPTH, 4: long-path buffer entries (power of two, ≥2)
- clk  in  1  rising-edge clock
- reset_n  in  1  reset, asynchronous, active-low
- alu_valid  in  1  ALU result present this cycle; no backpressure
- alu_rd  in  5  ALU destination register
- alu_data  in  32  ALU result
- long_valid  in  1  long-path result offered
- long_ready  out  1  long-path result accepted when valid&&ready
- long_rd  in  5  long-path destination
- long_data  in  32  long-path result
- rs_query, rt_query  in  5 each  decode-stage source registers
- rs_pending, rt_pending  out  1 each  queried register has an undelivered long-path write
- WENREG  out  1  register-file write enable (registered)
- Rd  out  5  register-file write address (registered)
- RdDATA  out  32  register-file write data (registered)

## Operation
- Port priority each cycle: ALU > buffer head > direct long-path bypass.
- ALU: alu_valid at edge N drives WENREG=1, Rd=alu_rd, RdDATA=alu_data after edge N (visible cycle N+1).
- Long path: accept when long_valid && long_ready. long_ready = !full (registered count, not full-with-pop).
- Bypass: accepted long result with buffer empty and alu_valid=0 goes straight to output register, latency 1; otherwise enqueued.
- Drain: alu_valid=0 and buffer non-empty → pop head to output. Same-cycle enqueue+pop allowed.
- $0: any write with rd==0 is issued with WENREG=0; rd==0 is never enqueued (accepted and dropped).
- Kill: ALU write to rd=X invalidates every buffered entry with rd==X (newer value wins). A popped invalid entry produces WENREG=0 for that cycle.
- Pending: rs_pending = rs_query≠0 and (any valid buffered entry has rd==rs_query, or output stage holds WENREG=1 with Rd==rs_query from the long path). Same for rt. Combinational from state.

## Timing
- Reset (async assert, synchronous-release behaviour irrelevant): WENREG=0, Rd=0, RdDATA=0, buffer empty, all valid bits 0, long_ready=1, rs/rt_pending=0.
- Reset mid-operation discards all buffered entries; no write issued for them.
- No valid write → WENREG=0; Rd/RdDATA hold last value.
- Full: long_ready=0 until a pop completes (ready returns cycle after pop).
- Pointer wrap modulo DEPTH; count width $clog2(DEPTH)+1.
- Simultaneous alu_valid, long accept and kill match on the incoming long result: incoming long entry is older-arriving but logically later; it is NOT killed.
- Continuous alu_valid starves the buffer; hazard unit must bound this via pending stalls.

## Structure
- Package mips_cpu_pkg: typedef wb_entry_t {logic valid; logic [4:0] rd; logic [31:0] data;}, localparam REG_ZERO = 5'd0.
- Sub-module mips_cpu_wb_fifo: DEPTH-entry circular buffer of wb_entry_t with push/pop/full/empty, parallel kill-by-rd port, and match outputs for two query addresses.
- Top: priority mux, output register, pending logic.

## Test plan
- Reset: hold reset_n=0 → WENREG=0, Rd=0, RdDATA=0, long_ready=1; release, idle 5 cycles → WENREG stays 0.
- ALU only: alu_valid, rd=8, data=32'hDEAD_BEEF → next cycle WENREG=1, Rd=8, RdDATA=DEADBEEF.
- Contention: alu_valid 3 cycles (rd=1,2,3) while long offers rd=9 data=0x55 → rd=1,2,3 written first, rd=9 on 4th; rs_query=9 → rs_pending=1 until write visible.
- Full: alu_valid held, long offers 5 results, DEPTH=4 → long_ready=0 after 4th; drop alu_valid → four writes in order, 5th accepted next cycle.
- Kill: buffer holds rd=7 data=0x11, ALU writes rd=7 data=0x22 → only 0x22 written; popped killed entry gives WENREG=0.
- $0 and reset mid-op: long rd=0 → accepted, no write; reset_n pulsed with 3 buffered entries → no writes afterward, long_ready=1.

Source files
------------

// File: rtl/mips_cpu_pkg.sv
// mips_cpu_pkg
// Shared types for the register-file write side of the MIPS core.
//   wb_entry_t : one pending register-file write (valid, destination, data)
//   REG_ZERO   : architectural $0, which is never actually written
package mips_cpu_pkg;

   typedef struct packed {
      logic        valid;
      logic [4:0]  rd;
      logic [31:0] data;
   } wb_entry_t;

   localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/mips_cpu_wb_fifo.sv
// mips_cpu_wb_fifo
// Circular buffer that holds long-latency (load / mul-div) results while the
// ALU owns the register-file write port.
// Ports:
//   clk, reset_n             clock, asynchronous active-low reset
//   push, push_entry         enqueue one entry at the tail
//   pop, head_entry          dequeue the oldest entry (head_entry is its content)
//   full, empty              occupancy flags from the registered count
//   kill_en, kill_rd         clear the valid bit of every stored entry with rd==kill_rd
//   query_a/b, match_a/b     an occupied, still-valid entry targets the queried register
module mips_cpu_wb_fifo
   import mips_cpu_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       push,
   input  wb_entry_t  push_entry,
   input  logic       pop,
   output wb_entry_t  head_entry,
   output logic       full,
   output logic       empty,
   input  logic       kill_en,
   input  logic [4:0] kill_rd,
   input  logic [4:0] query_a,
   input  logic [4:0] query_b,
   output logic       match_a,
   output logic       match_b
);

   localparam int PTR_W = $clog2(DEPTH);

   wb_entry_t          mem [DEPTH];
   logic [PTR_W-1:0]   head;
   logic [PTR_W-1:0]   tail;
   logic [PTR_W:0]     count;
   logic [PTR_W-1:0]   slot;

   assign head_entry = mem[head];
   assign full       = (count == (PTR_W+1)'(DEPTH));
   assign empty      = (count == '0);

   // Storage and pointers. DEPTH is a power of two, so the pointers wrap by
   // plain overflow. The kill sweep runs before the push write, so an entry
   // arriving in the same cycle as a kill keeps its valid bit: it is the
   // logically later write and must not be discarded.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (kill_en && mem[i].valid && (mem[i].rd == kill_rd)) begin
               mem[i].valid <= 1'b0;
            end
         end
         if (push) begin
            mem[tail] <= push_entry;
            tail      <= tail + PTR_W'(1);
         end
         if (pop) begin
            head <= head + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + (PTR_W+1)'(1);
            2'b01:   count <= count - (PTR_W+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Query matching walks the slots from head onward; only the first `count`
   // slots are occupied, because popped slots keep their stale contents.
   always_comb begin
      match_a = 1'b0;
      match_b = 1'b0;
      slot    = '0;
      for (int i = 0; i < DEPTH; i++) begin
         slot = head + PTR_W'(i);
         if (((PTR_W+1)'(i) < count) && mem[slot].valid) begin
            if (mem[slot].rd == query_a) match_a = 1'b1;
            if (mem[slot].rd == query_b) match_b = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mips_cpu_writeback_arbiter.sv
// mips_cpu_writeback_arbiter
// Merges the single-cycle ALU result path and the multi-cycle long path into
// the register file's single write port, buffering long results while the
// ALU is writing, and flags source registers with undelivered long writes.
// Ports:
//   clk, reset_n                         clock, asynchronous active-low reset
//   alu_valid, alu_rd, alu_data          ALU result (always taken, no backpressure)
//   long_valid, long_ready, long_rd,     long-path result, handshake valid&&ready
//   long_data
//   rs_query, rt_query                   decode-stage source registers
//   rs_pending, rt_pending               queried register has a long write in flight
//   WENREG, Rd, RdDATA                   registered register-file write port
module mips_cpu_writeback_arbiter
   import mips_cpu_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        alu_valid,
   input  logic [4:0]  alu_rd,
   input  logic [31:0] alu_data,
   input  logic        long_valid,
   output logic        long_ready,
   input  logic [4:0]  long_rd,
   input  logic [31:0] long_data,
   input  logic [4:0]  rs_query,
   input  logic [4:0]  rt_query,
   output logic        rs_pending,
   output logic        rt_pending,
   output logic        WENREG,
   output logic [4:0]  Rd,
   output logic [31:0] RdDATA
);

   logic      full;
   logic      empty;
   logic      match_rs;
   logic      match_rt;
   logic      long_accept;
   logic      push;
   logic      pop;
   logic      from_long;
   wb_entry_t head_entry;
   wb_entry_t push_entry;

   // Ready comes from the registered count only, so a full buffer stays
   // closed for the pop cycle itself and reopens the cycle after.
   assign long_ready  = !full;
   assign long_accept = long_valid && long_ready;

   // The buffer drains whenever the ALU leaves the port free. A long result
   // is buffered unless it can bypass straight to the port (no ALU write,
   // nothing older queued); writes to $0 are accepted but never stored.
   assign pop        = !alu_valid && !empty;
   assign push       = long_accept && (long_rd != REG_ZERO) && (alu_valid || !empty);
   assign push_entry = '{valid: 1'b1, rd: long_rd, data: long_data};

   mips_cpu_wb_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk        (clk),
      .reset_n    (reset_n),
      .push       (push),
      .push_entry (push_entry),
      .pop        (pop),
      .head_entry (head_entry),
      .full       (full),
      .empty      (empty),
      .kill_en    (alu_valid),
      .kill_rd    (alu_rd),
      .query_a    (rs_query),
      .query_b    (rt_query),
      .match_a    (match_rs),
      .match_b    (match_rt)
   );

   // Output register with fixed priority ALU > buffer head > bypass.
   // from_long remembers whether the value now on the port came from the
   // long path, because such a write still counts as pending for decode.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         WENREG    <= 1'b0;
         Rd        <= '0;
         RdDATA    <= '0;
         from_long <= 1'b0;
      end else if (alu_valid) begin
         WENREG    <= (alu_rd != REG_ZERO);
         Rd        <= alu_rd;
         RdDATA    <= alu_data;
         from_long <= 1'b0;
      end else if (!empty) begin
         WENREG    <= head_entry.valid && (head_entry.rd != REG_ZERO);
         Rd        <= head_entry.rd;
         RdDATA    <= head_entry.data;
         from_long <= 1'b1;
      end else if (long_accept) begin
         WENREG    <= (long_rd != REG_ZERO);
         Rd        <= long_rd;
         RdDATA    <= long_data;
         from_long <= 1'b1;
      end else begin
         WENREG    <= 1'b0;
         from_long <= 1'b0;
      end
   end

   // $0 is never pending; otherwise a queued valid entry or a long-path
   // write sitting on the port keeps the register pending.
   assign rs_pending = (rs_query != REG_ZERO) &&
                       (match_rs || (WENREG && from_long && (Rd == rs_query)));
   assign rt_pending = (rt_query != REG_ZERO) &&
                       (match_rt || (WENREG && from_long && (Rd == rt_query)));

endmodule
